branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
ID-stage branch resolver for the 5-stage MIPS32 pipeline. It sits directly downstream of the ID-stage equality comparator and consumes its o_is_equal result. It decides beq/bne outcome, computes the branch target, and drives PC select and the IF/ID flush. When a branch operand is still being produced by EX or MEM, it holds the pipeline for a fixed number of stall cycles before resolving. It also keeps resolved-branch and taken-branch counters for the debug unit.

Parameters:
PC_LEN, 32, width of PC, pc_plus4 and target
DATA_LEN, 32, width of sign-extended offset
CNT_LEN, 16, width of performance counters

Ports:
i_clk  in  1  system clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_halt  in  1  global pipeline freeze
i_id_valid  in  1  ID holds a valid instruction
i_branch_eq  in  1  ID instruction is beq
i_branch_ne  in  1  ID instruction is bne
i_is_equal  in  1  equality result from ID comparator (forwarded operands)
i_pc_plus4  in  PC_LEN  PC+4 of the branch
i_offset  in  DATA_LEN  sign-extended 16-bit immediate
i_dep_ex_alu  in  1  branch operand produced by ALU instr now in EX
i_dep_ex_load  in  1  branch operand produced by load now in EX
i_dep_mem_load  in  1  branch operand produced by load now in MEM
o_stall  out  1  freeze PC and IF/ID; bubble into ID/EX
o_pc_src  out  1  select o_branch_target as next PC
o_flush_if_id  out  1  squash the instruction in IF/ID
o_branch_target  out  PC_LEN  i_pc_plus4 + (i_offset << 2)
o_busy  out  1  FSM in WAIT
o_branch_cnt  out  CNT_LEN  branches resolved
o_taken_cnt  out  CNT_LEN  branches taken

Behaviour:
- Reset asserted (async, any time, including mid-WAIT): state=IDLE, cnt=0, both counters=0. o_stall, o_pc_src, o_flush_if_id and o_busy are 0.
- branch = i_id_valid & (i_branch_eq XOR i_branch_ne). If both eq and ne are set, the instruction is treated as a non-branch.
- Required stalls N: 2 if i_dep_ex_load; else 1 if i_dep_ex_alu or i_dep_mem_load; else 0.
- o_branch_target is always combinational: i_pc_plus4 + ({i_offset, 2'b00}), truncated to PC_LEN (wraps mod 2^PC_LEN).
- taken = (i_branch_eq & i_is_equal) | (i_branch_ne & ~i_is_equal).
- "Resolve" means:
  - o_pc_src = o_flush_if_id = taken, combinational in that cycle.
  - On the clock edge, o_branch_cnt increments and o_taken_cnt increments if taken.
  - Both counters wrap at 2^CNT_LEN.
- IDLE:
  - If branch and N=0: resolve this cycle; o_stall=0; stay IDLE.
  - If branch and N>0: o_stall=1; cnt<=N-1; go to WAIT; no resolve.
  - If not branch: all control outputs 0.
- WAIT (o_busy=1):
  - The dep_* inputs are ignored; the stall count is fixed at entry.
  - If cnt!=0: o_stall=1; cnt<=cnt-1.
  - If cnt==0: o_stall=0; resolve using the current i_is_equal; go to IDLE.
  - If i_id_valid drops in WAIT, go to IDLE with no resolve and no count.
- Stall lengths: N=1 gives exactly 1 stall cycle and resolves in cycle 2. N=2 gives 2 stall cycles and resolves in cycle 3.
- i_halt=1: state, cnt and counters are held. o_stall, o_pc_src and o_flush_if_id are forced to 0. o_busy reflects the held state.
- No output is asserted for more than one cycle per branch except o_stall and o_busy.

Decomposition:
- Shared pipeline package holds:
  - FSM state encoding (ST_IDLE=1'b0, ST_WAIT=1'b1).
  - Stall constants (STALL_LOAD_EX=2, STALL_ALU_EX=1, STALL_LOAD_MEM=1).
  - The offset shift amount (2).
- cnt is 2 bits. The block is flat; no sub-module. The comparator stays outside and its output is wired to i_is_equal.

Test Plan:
- beq, no deps, i_is_equal=1, pc_plus4=0x00000104, offset=0x00000003 -> same cycle: o_pc_src=1, o_flush_if_id=1, o_branch_target=0x00000110, o_stall=0; next cycle o_branch_cnt=1, o_taken_cnt=1.
- bne, no deps, i_is_equal=1, offset=0xFFFFFFFE, pc_plus4=0x00000010 -> o_pc_src=0, o_flush=0, o_branch_target=0x00000008; o_branch_cnt +1, o_taken_cnt unchanged.
- beq with i_dep_ex_load=1 -> o_stall=1 for cycles 0 and 1, o_busy=1 in cycles 1–2. Cycle 2: i_is_equal=1 gives o_pc_src=1, o_stall=0. Cycle 3: IDLE.
- beq with i_dep_ex_alu=1 and i_dep_mem_load=1 -> exactly one stall cycle, resolve in cycle 1. Toggling dep_* during WAIT has no effect.
- i_reset_n pulsed low during WAIT with cnt=1 -> immediately o_stall=0, o_busy=0, counters=0. After release, a branch with no deps resolves normally.
- Both eq and ne set -> no stall, no pc_src, counters unchanged. Then i_halt=1 during WAIT -> o_stall=0, state held; on release the remaining stalls complete.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the ID-stage branch resolver.
// State encoding, stall lengths and offset scaling.
package branch_resolve_unit_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] STALL_LOAD_EX  = 2'd2;
  localparam logic [1:0] STALL_ALU_EX   = 2'd1;
  localparam logic [1:0] STALL_LOAD_MEM = 2'd1;

  localparam int OFFSET_SHIFT = 2;

  // Load in EX needs the longest wait; other producers share one cycle.
  function automatic logic [1:0] stall_need(
    input logic ld_ex,
    input logic alu_ex,
    input logic ld_mem
  );
    logic [1:0] n;
    n = 2'd0;
    if (ld_ex)
      n = STALL_LOAD_EX;
    else if (alu_ex)
      n = STALL_ALU_EX;
    else if (ld_mem)
      n = STALL_LOAD_MEM;
    return n;
  endfunction

endpackage

// File: rtl/branch_resolve_unit.sv
// ID-stage beq/bne resolver: target, PC select, flush,
// fixed-length operand stalls and branch counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int PC_LEN   = 32,
  parameter int DATA_LEN = 32,
  parameter int CNT_LEN  = 16
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_halt,
  input  logic                i_id_valid,
  input  logic                i_branch_eq,
  input  logic                i_branch_ne,
  input  logic                i_is_equal,
  input  logic [PC_LEN-1:0]   i_pc_plus4,
  input  logic [DATA_LEN-1:0] i_offset,
  input  logic                i_dep_ex_alu,
  input  logic                i_dep_ex_load,
  input  logic                i_dep_mem_load,
  output logic                o_stall,
  output logic                o_pc_src,
  output logic                o_flush_if_id,
  output logic [PC_LEN-1:0]   o_branch_target,
  output logic                o_busy,
  output logic [CNT_LEN-1:0]  o_branch_cnt,
  output logic [CNT_LEN-1:0]  o_taken_cnt
);

  state_t     state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [1:0] need;
  logic       branch;
  logic       taken;
  logic       resolve;
  logic       stall;

  logic [DATA_LEN+OFFSET_SHIFT-1:0] off_sh;

  assign off_sh = {i_offset, {OFFSET_SHIFT{1'b0}}};
  assign o_branch_target = i_pc_plus4 + PC_LEN'(off_sh);

  assign branch = i_id_valid & (i_branch_eq ^ i_branch_ne);
  assign taken  = (i_branch_eq & i_is_equal) |
                  (i_branch_ne & ~i_is_equal);
  assign need   = stall_need(i_dep_ex_load, i_dep_ex_alu,
                             i_dep_mem_load);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    resolve = 1'b0;
    stall   = 1'b0;
    if (i_reset_n && !i_halt) begin
      unique case (state)
        ST_IDLE: begin
          if (branch) begin
            if (need == 2'd0) begin
              resolve = 1'b1;
            end else begin
              stall   = 1'b1;
              cnt_n   = need - 2'd1;
              state_n = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // dep_* are ignored here: the wait length was fixed on entry.
          if (!i_id_valid) begin
            state_n = ST_IDLE;
          end else if (cnt != 2'd0) begin
            stall = 1'b1;
            cnt_n = cnt - 2'd1;
          end else begin
            resolve = 1'b1;
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign o_stall       = stall;
  assign o_pc_src      = resolve & taken;
  assign o_flush_if_id = resolve & taken;
  assign o_busy        = (state == ST_WAIT);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= ST_IDLE;
      cnt          <= 2'd0;
      o_branch_cnt <= '0;
      o_taken_cnt  <= '0;
    end else if (!i_halt) begin
      state <= state_n;
      cnt   <= cnt_n;
      if (resolve) begin
        o_branch_cnt <= o_branch_cnt + CNT_LEN'(1);
        if (taken)
          o_taken_cnt <= o_taken_cnt + CNT_LEN'(1);
      end
    end
  end

endmodule
